// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the IF/ID pipeline register. Owns the
//   fetch PC and issues single-outstanding requests to instruction memory.
//   Returned words are queued in a small in-order buffer whose head is
//   presented to IF/ID. The stage obeys the same stall (hazard_i) and
//   redirect (flush_i) controls as IF/ID.
//
// Configuration macro:
//   FETCH_BUF_EN  defined   -> buffer depth 2 (one word fetched ahead)
//                 undefined -> buffer depth 1
//
// Ports:
//   clk_i         in   1   clock, rising edge
//   start_i       in   1   asynchronous active-low reset
//   hazard_i      in   1   IF/ID stall, presented word not consumed
//   flush_i       in   1   redirect to target_i, drop buffered/in-flight words
//   target_i      in  32   redirect address
//   imem_req_o    out  1   memory request valid
//   imem_addr_o   out 32   word-aligned request address
//   imem_ack_i    in   1   request accepted, data returned same cycle
//   imem_rdata_i  in  32   instruction word
//   pc_o          out 32   PC of presented instruction
//   inst_o        out 32   presented instruction (0 = bubble)
//   pcIm_o        out 12   B-type offset field of inst_o
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [11:0] pcIm_o
);

`ifdef FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // B-type branch offset field {inst[31],inst[7],inst[30:25],inst[11:8]}
  function automatic logic [11:0] btype_imm(input logic [31:0] inst);
    return {inst[31], inst[7], inst[30:25], inst[11:8]};
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic [31:0]             fetch_pc_r;
  logic [31:0]             fetch_pc_next_s;
  logic [31:0]             drain_addr_r;
  logic [31:0]             drain_addr_next_s;
  logic                    started_r;
  logic [1:0]              count_r;
  logic [1:0]              count_next_s;
  logic [DEPTH-1:0][31:0]  buf_pc_r;
  logic [DEPTH-1:0][31:0]  buf_inst_r;
  logic [DEPTH-1:0][31:0]  buf_pc_next_s;
  logic [DEPTH-1:0][31:0]  buf_inst_next_s;

  logic                    consume_s;
  logic                    pop_s;
  logic [1:0]              count_after_pop_s;
  logic                    issue_ok_s;
  logic                    req_s;
  logic [31:0]             addr_s;
  logic                    done_s;
  logic                    push_s;

  // Pop/occupancy bookkeeping shared by issue and buffer logic
  always_comb begin
    consume_s         = start_i & ~hazard_i & ~flush_i;
    pop_s             = consume_s & (count_r != 2'd0);
    count_after_pop_s = count_r - {1'b0, pop_s};
    // started_r holds requests off until the first edge after reset release
    issue_ok_s        = started_r & (count_after_pop_s < DEPTH_C);
  end

  // FSM next state and memory-side outputs
  always_comb begin
    state_next_s      = state_r;
    req_s             = 1'b0;
    addr_s            = fetch_pc_r;
    drain_addr_next_s = drain_addr_r;
    case (state_r)
      ST_RUN: begin
        req_s  = issue_ok_s;
        addr_s = fetch_pc_r;
        // a redirect that catches an unanswered request must wait it out
        if (flush_i & req_s & ~imem_ack_i) begin
          state_next_s      = ST_DRAIN;
          drain_addr_next_s = fetch_pc_r;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // keep the abandoned request stable until memory answers it
        req_s  = 1'b1;
        addr_s = drain_addr_r;
        if (imem_ack_i) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_RUN;
        req_s        = 1'b0;
        addr_s       = fetch_pc_r;
      end
    endcase
    done_s = req_s & imem_ack_i;
    // only RUN-state answers not overtaken by a redirect are kept
    push_s = done_s & (state_r == ST_RUN) & ~flush_i;
  end

  // Fetch PC update: redirect wins, otherwise advance on every kept word
  always_comb begin
    if (flush_i) begin
      fetch_pc_next_s = target_i & ~32'h0000_0003;
    end else if (push_s) begin
      fetch_pc_next_s = fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_next_s = fetch_pc_r;
    end
  end

  // In-order buffer next contents: shift on pop, then append at the tail
  always_comb begin
    buf_pc_next_s   = buf_pc_r;
    buf_inst_next_s = buf_inst_r;
    count_next_s    = count_r;
    if (flush_i) begin
      count_next_s = 2'd0;
    end else begin
      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          buf_pc_next_s[i]   = buf_pc_r[i+1];
          buf_inst_next_s[i] = buf_inst_r[i+1];
        end
      end else begin
        buf_pc_next_s   = buf_pc_r;
        buf_inst_next_s = buf_inst_r;
      end
      if (push_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (count_after_pop_s == 2'(i)) begin
            buf_pc_next_s[i]   = fetch_pc_r;
            buf_inst_next_s[i] = imem_rdata_i;
          end else begin
            buf_pc_next_s[i]   = buf_pc_next_s[i];
            buf_inst_next_s[i] = buf_inst_next_s[i];
          end
        end
        count_next_s = count_after_pop_s + 2'd1;
      end else begin
        count_next_s = count_after_pop_s;
      end
    end
  end

  // State, PC and buffer registers
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_r      <= ST_RUN;
      fetch_pc_r   <= RESET_PC;
      drain_addr_r <= RESET_PC;
      started_r    <= 1'b0;
      count_r      <= 2'd0;
      buf_pc_r     <= '0;
      buf_inst_r   <= '0;
    end else begin
      state_r      <= state_next_s;
      fetch_pc_r   <= fetch_pc_next_s;
      drain_addr_r <= drain_addr_next_s;
      started_r    <= 1'b1;
      count_r      <= count_next_s;
      buf_pc_r     <= buf_pc_next_s;
      buf_inst_r   <= buf_inst_next_s;
    end
  end

  // Presented instruction comes only from registered buffer state
  always_comb begin
    imem_req_o  = req_s;
    imem_addr_o = addr_s;
    if (count_r != 2'd0) begin
      pc_o   = buf_pc_r[0];
      inst_o = buf_inst_r[0];
    end else begin
      pc_o   = fetch_pc_r;
      inst_o = 32'h0000_0000;
    end
    if (inst_o == 32'h0000_0000) begin
      pcIm_o = 12'h000;
    end else begin
      pcIm_o = btype_imm(inst_o);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A queue-based reference model tracks
//   the fetch PC, the buffered {pc,inst} entries and whether a redirected
//   request is still awaiting its answer. Directed scenarios are followed by
//   randomized hazard/flush/ack traffic with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        start;
  logic        hazard;
  logic        flush;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] pcim;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk_i       (clk),
    .start_i     (start),
    .hazard_i    (hazard),
    .flush_i     (flush),
    .target_i    (target),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_rdata_i(imem_rdata),
    .pc_o        (pc),
    .inst_o      (inst),
    .pcIm_o      (pcim)
  );

  always #5 clk = ~clk;

  // reference model state
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_daddr;
  bit          m_drain;
  bit          m_started;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] b_off(input logic [31:0] w);
    return {w[31], w[7], w[30:25], w[11:8]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc      = RPC;
    m_daddr   = RPC;
    m_drain   = 1'b0;
    m_started = 1'b0;
  endtask

  // One clock cycle: entered and left at posedge+1
  task automatic step(input bit hz, input bit fl, input logic [31:0] tg,
                      input bit ak, input logic [31:0] rd);
    logic [31:0] e_pc, e_inst, e_addr;
    bit          e_req, pop, done;
    hazard     = hz;
    flush      = fl;
    target     = tg;
    imem_ack   = ak;
    imem_rdata = rd;
    #2;
    pop    = !hz && !fl && (mq.size() > 0);
    e_req  = m_drain ? 1'b1 : (m_started && ((mq.size() - int'(pop)) < DEPTH));
    e_addr = m_drain ? m_daddr : m_pc;
    e_inst = (mq.size() > 0) ? mq[0].inst : 32'h0;
    e_pc   = (mq.size() > 0) ? mq[0].pc : m_pc;
    check_eq("req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) check_eq("addr", imem_addr, e_addr);
    check_eq("pc", pc, e_pc);
    check_eq("inst", inst, e_inst);
    check_eq("pcim", {20'h0, pcim}, {20'h0, (e_inst == 32'h0) ? 12'h0 : b_off(e_inst)});
    done = e_req && ak;
    if (fl) begin
      mq.delete();
      if (m_drain) begin
        if (done) m_drain = 1'b0;
      end else if (e_req && !ak) begin
        m_drain = 1'b1;
        m_daddr = m_pc;
      end
      m_pc = tg & 32'hFFFF_FFFC;
    end else if (m_drain) begin
      if (done) m_drain = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (done) begin
        mq.push_back({m_pc, rd});
        m_pc = m_pc + 32'd4;
      end
    end
    m_started = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must settle with no clock edge
  task automatic async_reset();
    start = 1'b0;
    #1;
    check_eq("rst_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_addr", imem_addr, RPC);
    check_eq("rst_pc", pc, RPC);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_pcim", {20'h0, pcim}, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
  endtask

  logic [31:0] words [5];

  initial begin
    start      = 1'b0;
    hazard     = 1'b0;
    flush      = 1'b0;
    target     = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    model_reset();
    words[0] = 32'h0000_00A0;
    words[1] = 32'h0000_00A1;
    words[2] = 32'h0000_00A2;
    words[3] = 32'h0000_00A3;
    words[4] = 32'hFE00_08E3;
    @(posedge clk);
    #1;
    async_reset();

    // zero-wait sequential fetch; first cycle after release issues nothing
    step(0, 0, 32'h0, 1, 32'hBAD0_0000);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 32'h0, 1, words[k]);
      check_eq("zw_inst", inst, words[k]);
      check_eq("zw_pc", pc, RPC + 32'(4 * k));
    end
    check_eq("zw_beq_off", {20'h0, pcim}, 32'h0000_0FF8);

    // slow memory: ack three cycles after the request rises
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 32'h0, 1, 32'h1234_5600 + 32'(r));
    end

    // stall for five cycles with zero-wait memory, then release
    for (int k = 0; k < 5; k++) step(1, 0, 32'h0, 1, 32'hC000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) step(0, 0, 32'h0, 1, 32'hC100_0000 + 32'(k));

    // flush while a request waits; its answer must be dropped
    step(0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 32'h0000_0200, 0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'hDEAD_0108);
    step(0, 0, 32'h0, 1, 32'h0000_2001);
    step(0, 0, 32'h0, 1, 32'h0000_2002);

    // flush, hazard and ack together; then flush with idle request
    step(1, 1, 32'h0000_0300, 1, 32'hDEAD_0001);
    step(0, 0, 32'h0, 1, 32'h0000_3001);
    step(1, 0, 32'h0, 0, 32'h0);
    step(1, 1, 32'h0000_0341, 1, 32'hDEAD_0002);
    step(1, 0, 32'h0, 1, 32'h0000_3401);

    // repeated flush during DRAIN, then a held double flush
    step(0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 32'h0000_0400, 0, 32'h0);
    step(0, 1, 32'h0000_0480, 0, 32'h0);
    step(0, 0, 32'h0, 1, 32'hDEAD_0003);
    step(0, 0, 32'h0, 1, 32'h0000_4801);
    step(0, 1, 32'h0000_0500, 1, 32'hDEAD_0004);
    step(0, 1, 32'h0000_0600, 1, 32'hDEAD_0005);
    step(0, 0, 32'h0, 1, 32'h0000_6001);

    // reset mid-request, and again during DRAIN
    step(0, 0, 32'h0, 0, 32'h0);
    async_reset();
    step(0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 32'h0000_0700, 0, 32'h0);
    async_reset();
    step(0, 0, 32'h0, 1, 32'h0000_0001);
    step(0, 0, 32'h0, 1, 32'h0000_0002);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        async_reset();
      end else begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
             $urandom, $urandom_range(0, 99) < 60, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that drives the IF/ID pipeline register. It owns the fetch PC and issues single-outstanding requests to instruction memory. Returned words go into a small in-order buffer and are presented as `pc_o`/`inst_o`/`pcIm_o` to IF/ID. It obeys the same `hazard_i` (stall) and `flush_i` (redirect) controls that IF/ID sees, so both ends stay consistent.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset.

Ports:
- `clk_i`, input, 1: clock. All state updates on the rising edge.
- `start_i`, input, 1: reset. Asynchronous, active-low. Low means reset asserted.
- `hazard_i`, input, 1: stall. IF/ID does not consume the presented instruction this cycle.
- `flush_i`, input, 1: redirect the fetch PC to `target_i`. Discard buffered and in-flight instructions.
- `target_i`, input, 32: redirect address, sampled when `flush_i`=1.
- `imem_req_o`, output, 1: instruction memory request valid.
- `imem_addr_o`, output, 32: request address, word aligned.
- `imem_ack_i`, input, 1: memory accepts the request and returns data in the same cycle.
- `imem_rdata_i`, input, 32: instruction word, valid when `imem_ack_i`=1.
- `pc_o`, output, 32: PC of the presented instruction.
- `inst_o`, output, 32: presented instruction. 32'h0 is a bubble.
- `pcIm_o`, output, 12: B-type offset of `inst_o`, {inst[31],inst[7],inst[30:25],inst[11:8]}. 12'h0 when `inst_o` is a bubble.

## Operation
- **Consume event:** `consume` = `start_i` & ~`hazard_i` & ~`flush_i`.
  - Buffer non-empty: the head entry is popped on `consume`.
  - Buffer empty: `inst_o`=0, `pcIm_o`=0, `pc_o`=`fetch_pc`.
- **Buffer:** in-order, holds {pc, inst}. Depth is 2 with `FETCH_BUF_EN`, 1 without. The head drives the outputs combinationally.
- **Request protocol:**
  - At most one request is outstanding.
  - Once `imem_req_o` rises, it and `imem_addr_o` are held stable until the cycle with `imem_ack_i`=1.
  - A request completes in the cycle where `imem_req_o` & `imem_ack_i`. Zero-wait acks are allowed.
- **Issue rule (RUN state):** assert `imem_req_o` with `imem_addr_o`=`fetch_pc` whenever occupancy after this cycle's pop is less than depth.
  - Issue is not gated by `hazard_i`.
  - On ack: push {`fetch_pc`, `imem_rdata_i`} and set `fetch_pc` += 4. Wrap modulo 2^32.
  - A push and a pop in the same cycle are both performed. Occupancy is unchanged.
- **States:**
  - RUN: normal fetch.
  - DRAIN: redirect pending, in-flight response is to be discarded.
- **Transitions:**
  - RUN → DRAIN: `flush_i`=1 while a request is outstanding without ack this cycle.
  - DRAIN → RUN: `imem_ack_i`=1. The data is discarded and no push occurs.
  - In DRAIN, `imem_req_o` stays high with the old address until ack. No new request is issued before RUN.
- **Flush:**
  - The buffer is cleared next edge and `fetch_pc` <= `target_i` & ~32'h3.
  - Flush takes priority over hazard and over pop.
  - Flush coincident with ack: the data is discarded and the block stays in RUN. The next request, to `target_i`, may issue on the following cycle.
- **Repeated flush:**
  - A second `flush_i` in DRAIN overwrites `fetch_pc` with the new target and stays in DRAIN.
  - A flush held for two cycles (IF/ID double-flush) redirects to the target given in the last flush cycle.

## Timing
- **Reset values (`start_i`=0, asynchronous):**
  - State RUN, buffer empty, `fetch_pc`=`RESET_PC`.
  - Outputs: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `pc_o`=`RESET_PC`, `inst_o`=0, `pcIm_o`=0.
- **Release:** `imem_req_o` rises in the first cycle after `start_i` is sampled high at a clock edge.
- **Fetch latency:** an ack at edge N is visible on `inst_o` in cycle N+1. With zero-wait memory and no stalls, a new instruction is presented every cycle.
- **Flush latency:** flush at edge N with no request outstanding gives `imem_addr_o`=`target_i` in cycle N+1.
- **Reset mid-request:** the request is dropped immediately. The memory side must tolerate abandonment.
- **Combinational paths:**
  - `imem_req_o` depends combinationally on `hazard_i`/`flush_i` only through the occupancy check.
  - `inst_o`, `pc_o` and `pcIm_o` have no combinational path from memory inputs.

## Configuration
- `FETCH_BUF_EN` defined: buffer depth 2. One instruction can be fetched ahead during a stall, and back-to-back fetch sustains 1 instruction per cycle even when a stall releases.
- Undefined: depth 1. Issue requires the buffer to be empty or popping this cycle. Throughput drops only after stalls. Protocol and flush behaviour are identical.

## Test plan
- **Zero-wait sequential fetch.** Stimulus: `RESET_PC`=0x100, ack every cycle, words 0xA0…0xA3. Response: `pc_o`=0x100,0x104,0x108,0x10C in consecutive cycles with matching `inst_o`; `pcIm_o` correct for a BEQ word 0xFE0008E3 (12'hFF8).
- **Slow memory.** Stimulus: ack 3 cycles after `imem_req_o` rises. Response: `imem_addr_o` stable across the wait, `inst_o`=0 until ack+1, exactly 1 request outstanding.
- **Stall with full buffer.** Stimulus: `FETCH_BUF_EN`, `hazard_i`=1 for 5 cycles. Response: 2 entries captured, `imem_req_o`=0 afterward, `inst_o` held at the first entry; release presents both in order.
- **Flush with request outstanding.** Stimulus: `target_i`=0x200 while a request to 0x108 waits. Response: 0x108 data discarded, next `imem_addr_o`=0x200, no 0x108 instruction ever on `inst_o`.
- **Coincident events.** Stimulus: flush, hazard and ack in the same cycle. Response: buffer empty, data dropped, request to the target the next cycle.
- **Reset mid-request.** Stimulus: `start_i` low mid-wait and again during DRAIN. Response: all outputs at reset values with no clock edge; restart from `RESET_PC`.
